// File: rtl/sram_port_arbiter_if.sv
// Bundle of the IF/MEM requester ports and the SRAM strobe bus around sram_port_arbiter.
// slave = arbiter side, master = pipeline/SRAM side.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              sram_cs;
    logic              sram_oe;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    logic              busy;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_dout,
        output if_ready, if_rdata, mem_ready, mem_rdata,
               sram_cs, sram_oe, sram_we, sram_addr, sram_din, busy
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_dout,
        input  if_ready, if_rdata, mem_ready, mem_rdata,
               sram_cs, sram_oe, sram_we, sram_addr, sram_din, busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data memory: grants one
// port, holds registered strobes for WAIT_CYC cycles, then pulses that port's ready.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_CYC   = 2,
    parameter int MAX_STREAK = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_port_arbiter_if.slave     bus
);
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int STK_W = $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STK_W-1:0]  streak_q, streak_d;
    logic              owner_q, owner_d;      // 1 = MEM port owns the access
    logic              cs_q, cs_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              grant_mem;

    // MEM normally wins; a waiting IF is forced through once MEM has had MAX_STREAK turns.
    assign grant_mem = bus.mem_req && !(bus.if_req && (streak_q == STK_MAX));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        cs_d        = cs_q;
        oe_d        = oe_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    owner_d = grant_mem;
                    cs_d    = 1'b1;
                    if (grant_mem) begin
                        oe_d   = !bus.mem_we;
                        we_d   = bus.mem_we;
                        addr_d = bus.mem_addr;
                        din_d  = bus.mem_wdata;
                        if (!bus.if_req)
                            streak_d = '0;
                        else if (streak_q != STK_MAX)
                            streak_d = streak_q + 1'b1;
                    end else begin
                        oe_d     = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        streak_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cs_d    = 1'b0;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    if (owner_q) begin
                        mem_ready_d = 1'b1;
                        if (!we_q) mem_rdata_d = bus.sram_dout;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.sram_dout;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            owner_q     <= 1'b0;
            cs_q        <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.sram_cs   = cs_q;
    assign bus.sram_oe   = oe_q;
    assign bus.sram_we   = we_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_din  = din_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: single-transaction vector table, then
// arbitration, starvation, reset and dropped-request sequences against a small SRAM model.
module tb_sram_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(2), .MAX_STREAK(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SRAM model: synchronous write, combinational read while selected.
    logic [DW-1:0] sram [0:255];
    always @(posedge clk) begin
        if (!rst_n) begin
            sram[8'h10] <= 32'hDEADBEEF;
            sram[8'h30] <= 32'hCAFEF00D;
        end else if (bus.sram_cs && bus.sram_we) begin
            sram[bus.sram_addr[7:0]] <= bus.sram_din;
        end
    end
    assign bus.sram_dout = (bus.sram_cs && bus.sram_oe) ? sram[bus.sram_addr[7:0]] : '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled every cycle on the falling edge.
    always @(negedge clk) begin
        check("ready_exclusive", 64'(bus.if_ready && bus.mem_ready), 64'd0);
        check("we_oe_exclusive", 64'(bus.sram_we && bus.sram_oe), 64'd0);
        check("strobe_outside_busy", 64'((bus.sram_cs || bus.sram_oe || bus.sram_we) && !bus.busy), 64'd0);
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        mr;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic run_txn(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                           input logic [31:0] ma, input logic [31:0] md,
                           output int lat, output logic got_if, output logic got_mem,
                           output int n_oe, output int n_we);
        bus.if_req = ir; bus.if_addr = ia;
        bus.mem_req = mr; bus.mem_we = mw; bus.mem_addr = ma; bus.mem_wdata = md;
        lat = 0; got_if = 1'b0; got_mem = 1'b0; n_oe = 0; n_we = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.sram_cs && bus.sram_oe) n_oe++;
            if (bus.sram_cs && bus.sram_we) n_we++;
            if (bus.if_ready || bus.mem_ready) begin
                lat = c; got_if = bus.if_ready; got_mem = bus.mem_ready;
                break;
            end
        end
        bus.if_req = 1'b0;
        bus.mem_req = 1'b0;
    endtask

    vec_t vecs [9];
    int   lat, n_oe, n_we;
    logic got_if, got_mem;

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0;

        vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h10, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h20, 32'h12345678,  1'b1, 32'h20, 32'h0};
        vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h20, 32'h0,         1'b1, 32'h20, 32'h12345678};
        vecs[3] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h20, 32'h12345678};
        vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h30, 32'h0,         1'b1, 32'h30, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 32'h30, 1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 32'h10, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'hA5A5A5A5,  1'b1, 32'h40, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 32'h40, 32'hA5A5A5A5};
        vecs[8] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h99, 32'h0,         1'b0, 32'h40, 32'hA5A5A5A5};

        tick(); tick();
        check("rst_cs", 64'(bus.sram_cs), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_addr", 64'(bus.sram_addr), 64'd0);
        check("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
        check("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
        check("rst_ready", 64'({bus.if_ready, bus.mem_ready}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            logic is_wr;
            is_wr = vecs[i].exp_mem && vecs[i].mw;
            run_txn(vecs[i].ir, vecs[i].ia, vecs[i].mr, vecs[i].mw, vecs[i].ma, vecs[i].md,
                    lat, got_if, got_mem, n_oe, n_we);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_if_ready", i), 64'(got_if), 64'(!vecs[i].exp_mem));
            check($sformatf("v%0d_mem_ready", i), 64'(got_mem), 64'(vecs[i].exp_mem));
            check($sformatf("v%0d_oe_cycles", i), 64'(n_oe), is_wr ? 64'd0 : 64'd2);
            check($sformatf("v%0d_we_cycles", i), 64'(n_we), is_wr ? 64'd2 : 64'd0);
            check($sformatf("v%0d_addr_hold", i), 64'(bus.sram_addr), 64'(vecs[i].exp_addr));
            check($sformatf("v%0d_rdata", i),
                  vecs[i].exp_mem ? 64'(bus.mem_rdata) : 64'(bus.if_rdata), 64'(vecs[i].exp_rd));
            tick();
            check($sformatf("v%0d_idle_after", i), 64'(bus.busy), 64'd0);
        end

        // Simultaneous requests: MEM first, IF four cycles later.
        begin
            int tm, ti;
            tm = 0; ti = 0;
            bus.if_req = 1; bus.if_addr = 32'h10;
            bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h20;
            for (int c = 1; c <= 30 && (tm == 0 || ti == 0); c++) begin
                tick();
                if (bus.mem_ready) begin
                    tm = c; bus.mem_req = 0;
                    check("sim_mem_rdata", 64'(bus.mem_rdata), 64'h12345678);
                end
                if (bus.if_ready) begin
                    ti = c; bus.if_req = 0;
                    check("sim_if_rdata", 64'(bus.if_rdata), 64'hDEADBEEF);
                end
            end
            check("sim_mem_first", 64'(tm), 64'd3);
            check("sim_if_second", 64'(ti), 64'd7);
            tick();
        end

        // Starvation: MEM held with fresh addresses, IF held; expect M,M,M,I,M.
        begin
            logic        exp_own [5];
            logic        own     [5];
            int          t_done  [5];
            logic [31:0] maddr   [4];
            logic [31:0] mexp    [4];
            int n, mi;
            exp_own = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            maddr   = '{32'h10, 32'h20, 32'h40, 32'h10};
            mexp    = '{32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'hDEADBEEF};
            n = 0; mi = 0;
            bus.if_req = 1; bus.if_addr = 32'h30;
            bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = maddr[0];
            for (int c = 1; c <= 40 && n < 5; c++) begin
                tick();
                if (bus.mem_ready || bus.if_ready) begin
                    own[n] = bus.mem_ready; t_done[n] = c;
                    if (bus.mem_ready) begin
                        check($sformatf("stv_mem_rdata%0d", mi), 64'(bus.mem_rdata), 64'(mexp[mi]));
                        mi++;
                        if (mi < 4) bus.mem_addr = maddr[mi];
                    end else begin
                        check("stv_if_rdata", 64'(bus.if_rdata), 64'hCAFEF00D);
                    end
                    n++;
                end
            end
            bus.if_req = 0; bus.mem_req = 0;
            check("stv_count", 64'(n), 64'd5);
            for (int k = 0; k < n; k++) begin
                check($sformatf("stv_owner%0d", k), 64'(own[k]), 64'(exp_own[k]));
                check($sformatf("stv_time%0d", k), 64'(t_done[k]), 64'(3 + 4 * k));
            end
            tick();
        end

        // Reset during the second ACCESS cycle of an IF read.
        bus.if_req = 1; bus.if_addr = 32'h10;
        tick(); tick();
        check("rstmid_in_access", 64'({bus.sram_cs, bus.sram_oe}), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_cs", 64'({bus.sram_cs, bus.sram_oe, bus.sram_we}), 64'd0);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_addr", 64'(bus.sram_addr), 64'd0);
        check("rstmid_if_rdata", 64'(bus.if_rdata), 64'd0);
        check("rstmid_mem_rdata", 64'(bus.mem_rdata), 64'd0);
        bus.if_req = 0;
        tick();
        check("rstmid_no_ready1", 64'({bus.if_ready, bus.mem_ready}), 64'd0);
        tick();
        check("rstmid_no_ready2", 64'({bus.if_ready, bus.mem_ready}), 64'd0);
        rst_n = 1'b1;
        tick();
        run_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, lat, got_if, got_mem, n_oe, n_we);
        check("rstmid_retry_lat", 64'(lat), 64'd3);
        check("rstmid_retry_if", 64'(got_if), 64'd1);
        check("rstmid_retry_rdata", 64'(bus.if_rdata), 64'hDEADBEEF);
        tick();

        // IF request dropped after grant still completes exactly once.
        begin
            int np, pc;
            np = 0; pc = 0;
            bus.if_req = 1; bus.if_addr = 32'h20;
            tick();
            bus.if_req = 0;
            bus.if_addr = 32'h30;
            for (int c = 1; c <= 6; c++) begin
                tick();
                if (bus.if_ready) begin np++; pc = c; end
                if (c == 3) check("drop_busy_after", 64'(bus.busy), 64'd0);
            end
            check("drop_pulses", 64'(np), 64'd1);
            check("drop_pulse_time", 64'(pc), 64'd2);
            check("drop_rdata", 64'(bus.if_rdata), 64'h12345678);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
